// File: rtl/button_pulse_array_pkg.sv
// Shared definitions for the pushbutton front end: channel FSM encoding and
// the elaboration-time counter width check.
package button_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t BTN_IDLE   = 2'd0;
    localparam btn_state_t BTN_HELD   = 2'd1;
    localparam btn_state_t BTN_REPEAT = 2'd2;

    // True when a cnt_w-bit unsigned counter can represent every cycle count
    // the channel needs to reach.
    function automatic bit cnt_w_fits(input int cnt_w, input int db_cycles,
                                      input int hold_cycles, input int repeat_cycles);
        longint max_v;
        max_v = longint'(db_cycles);
        if (longint'(hold_cycles) > max_v) max_v = longint'(hold_cycles);
        if (longint'(repeat_cycles) > max_v) max_v = longint'(repeat_cycles);
        if (cnt_w < 1) return 1'b0;
        if (cnt_w >= 32) return 1'b1;
        return max_v < (longint'(1) << cnt_w);
    endfunction

endpackage

// File: rtl/button_pulse_array_channel.sv
// One pushbutton channel: two-flop synchroniser, counting debouncer and the
// press / hold / auto-repeat state machine with registered single-cycle pulses.
module button_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic level,
    output logic pulse_press,
    output logic pulse_release,
    output logic pulse_repeat
);

    if (!cnt_w_fits(CNT_W, DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) begin : g_bad_cnt_w
        $error("button_channel: CNT_W=%0d cannot hold the configured cycle counts", CNT_W);
    end
    if (DB_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("button_channel: DB_CYCLES must be >=1, HOLD/REPEAT_CYCLES >=2");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             rise, fall;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;

        // The accepted toggle and the FSM reaction land on the same edge, so
        // level and its pulse rise together.
        level_d  = level_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
                rise    = sync2_q;
                fall    = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;
        if (fall) begin
            // Release pre-empts any repeat due on the same cycle.
            state_d    = BTN_IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
            release_d  = 1'b1;
        end else begin
            case (state_q)
                BTN_IDLE: begin
                    if (rise) begin
                        press_d    = 1'b1;
                        state_d    = BTN_HELD;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end
                end
                BTN_HELD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (repeat_en) begin
                            repeat_d   = 1'b1;
                            state_d    = BTN_REPEAT;
                            hold_cnt_d = '0;
                            rep_cnt_d  = '0;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                BTN_REPEAT: begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d = '0;
                        repeat_d  = repeat_en;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = BTN_IDLE;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            state_q    <= BTN_IDLE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign level         = level_q;
    assign pulse_press   = press_q;
    assign pulse_release = release_q;
    assign pulse_repeat  = repeat_q;

endmodule

// File: rtl/button_pulse_array.sv
// N-channel pushbutton front end: an array of independent button_channel
// instances, one per pad input.
module button_pulse_array #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 4,
    parameter int HOLD_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse_press,
    output logic [N-1:0] pulse_release,
    output logic [N-1:0] pulse_repeat
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clock        (clock),
            .rst          (rst),
            .btn_raw      (btn_raw[i]),
            .repeat_en    (repeat_en[i]),
            .level        (level[i]),
            .pulse_press  (pulse_press[i]),
            .pulse_release(pulse_release[i]),
            .pulse_repeat (pulse_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_array.sv
// Scoreboard bench for button_pulse_array (N=2, DB=4, HOLD=20, REPEAT=8):
// expected pulse events are queued as stimulus is driven and matched against observed pulses.
module tb_button_pulse_array;

    localparam int N             = 2;
    localparam int DB_CYCLES     = 4;
    localparam int HOLD_CYCLES   = 20;
    localparam int REPEAT_CYCLES = 8;
    localparam int CNT_W         = 16;
    localparam int LAT           = DB_CYCLES + 2;
    localparam int K_PRESS       = 0;
    localparam int K_RELEASE     = 1;
    localparam int K_REPEAT      = 2;

    logic         clock;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] repeat_en;
    logic [N-1:0] level;
    logic [N-1:0] pulse_press;
    logic [N-1:0] pulse_release;
    logic [N-1:0] pulse_repeat;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int obs_q[$];

    button_pulse_array #(
        .N            (N),
        .DB_CYCLES    (DB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .repeat_en    (repeat_en),
        .level        (level),
        .pulse_press  (pulse_press),
        .pulse_release(pulse_release),
        .pulse_repeat (pulse_repeat)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Event key: cycle*8 + channel*4 + kind; the cycle is the edge count at which the pulse is visible.
    always @(negedge clock) begin
        for (int ch = 0; ch < N; ch++) begin
            if (pulse_press[ch])   obs_q.push_back(cyc * 8 + ch * 4 + K_PRESS);
            if (pulse_release[ch]) obs_q.push_back(cyc * 8 + ch * 4 + K_RELEASE);
            if (pulse_repeat[ch])  obs_q.push_back(cyc * 8 + ch * 4 + K_REPEAT);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic expect_ev(input int c, input int ch, input int kind);
        exp_q.push_back(c * 8 + ch * 4 + kind);
    endtask

    task automatic test_reset();
        int r, n, e, o;
        rst       = 1'b1;
        btn_raw   = 2'b11;
        repeat_en = 2'b00;
        wait_until(3);
        obs_q.delete();
        exp_q.delete();
        vectors++;
        if (level !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_level: got %b expected 00", level);
        end
        vectors++;
        if ({pulse_press, pulse_release, pulse_repeat} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: got %b expected 000000", {pulse_press, pulse_release, pulse_repeat});
        end
        r   = cyc;
        rst = 1'b0;
        expect_ev(r + LAT, 0, K_PRESS);
        expect_ev(r + LAT, 1, K_PRESS);
        wait_until(r + LAT - 1);
        vectors++;
        if (level !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_level_early: got %b expected 00", level);
        end
        wait_until(r + LAT);
        vectors++;
        if (level !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_level_rise: got %b expected 11", level);
        end
        wait_until(r + 9);
        btn_raw = 2'b00;
        expect_ev(r + 9 + LAT, 0, K_RELEASE);
        expect_ev(r + 9 + LAT, 1, K_RELEASE);
        wait_until(r + 20);
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    task automatic test_press_release();
        int c, n, e, o;
        c = cyc;
        obs_q.delete();
        exp_q.delete();
        repeat_en  = 2'b11;
        btn_raw[0] = 1'b1;
        expect_ev(c + LAT, 0, K_PRESS);
        wait_until(c + LAT - 1);
        vectors++;
        if (level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pr_level_before: got %b expected 0", level[0]);
        end
        wait_until(c + LAT);
        vectors++;
        if (level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pr_level_rise: got %b expected 1", level[0]);
        end
        wait_until(c + 10);
        btn_raw[0] = 1'b0;
        expect_ev(c + 10 + LAT, 0, K_RELEASE);
        wait_until(c + 10 + LAT - 1);
        vectors++;
        if (level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pr_level_held: got %b expected 1", level[0]);
        end
        wait_until(c + 10 + LAT);
        vectors++;
        if (level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pr_level_fall: got %b expected 0", level[0]);
        end
        wait_until(c + 22);
        repeat_en = 2'b00;
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL pr_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    task automatic test_glitch();
        int c, c2, n, e, o;
        c = cyc;
        obs_q.delete();
        exp_q.delete();
        btn_raw[1] = 1'b1;
        wait_until(c + 3);
        btn_raw[1] = 1'b0;
        wait_until(c + 5);
        btn_raw[1] = 1'b1;
        wait_until(c + 8);
        btn_raw[1] = 1'b0;
        wait_until(c + 9);
        vectors++;
        if (level[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_level_mid: got %b expected 0", level[1]);
        end
        wait_until(c + 13);
        vectors++;
        if (level[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_level_end: got %b expected 0", level[1]);
        end
        // A pulse exactly DB_CYCLES long is the shortest one that is accepted.
        c2 = c + 14;
        wait_until(c2);
        btn_raw[1] = 1'b1;
        expect_ev(c2 + LAT, 1, K_PRESS);
        wait_until(c2 + DB_CYCLES);
        btn_raw[1] = 1'b0;
        expect_ev(c2 + DB_CYCLES + LAT, 1, K_RELEASE);
        wait_until(c2 + LAT);
        vectors++;
        if (level[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_min_pulse_level: got %b expected 1", level[1]);
        end
        wait_until(c2 + 16);
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL glitch_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int c, t, n, e, o;
        c = cyc;
        t = c + LAT;
        obs_q.delete();
        exp_q.delete();
        repeat_en[0] = 1'b1;
        btn_raw[0]   = 1'b1;
        expect_ev(t, 0, K_PRESS);
        for (int k = 0; k < 4; k++) expect_ev(t + HOLD_CYCLES + k * REPEAT_CYCLES, 0, K_REPEAT);
        wait_until(c + 50);
        btn_raw[0] = 1'b0;
        expect_ev(c + 50 + LAT, 0, K_RELEASE);
        wait_until(c + 62);
        repeat_en = 2'b00;
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL repeat_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    task automatic test_late_repeat_enable();
        int c, t0, t1, n, e, o;
        c  = cyc;
        t0 = c + LAT;
        t1 = c + 3 + LAT;
        obs_q.delete();
        exp_q.delete();
        repeat_en  = 2'b10;
        btn_raw[0] = 1'b1;
        expect_ev(t0, 0, K_PRESS);
        wait_until(c + 3);
        btn_raw[1] = 1'b1;
        expect_ev(t1, 1, K_PRESS);
        for (int k = 0; k < 5; k++) expect_ev(t1 + HOLD_CYCLES + k * REPEAT_CYCLES, 1, K_REPEAT);
        wait_until(t0 + 30);
        repeat_en[0] = 1'b1;
        for (int k = 0; k < 4; k++) expect_ev(t0 + 31 + k * REPEAT_CYCLES, 0, K_REPEAT);
        wait_until(c + 56);
        btn_raw[0] = 1'b0;
        expect_ev(c + 56 + LAT, 0, K_RELEASE);
        wait_until(c + 60);
        btn_raw[1] = 1'b0;
        expect_ev(c + 60 + LAT, 1, K_RELEASE);
        wait_until(c + 72);
        repeat_en = 2'b00;
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL late_en_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    task automatic test_release_on_wrap();
        int c, t, n, e, o;
        c = cyc;
        t = c + LAT;
        obs_q.delete();
        exp_q.delete();
        repeat_en[0] = 1'b1;
        btn_raw[0]   = 1'b1;
        expect_ev(t, 0, K_PRESS);
        expect_ev(t + HOLD_CYCLES, 0, K_REPEAT);
        expect_ev(t + HOLD_CYCLES + REPEAT_CYCLES, 0, K_REPEAT);
        // Debounced fall lands exactly on the next repeat wrap.
        wait_until(t + HOLD_CYCLES + 2 * REPEAT_CYCLES - LAT);
        btn_raw[0] = 1'b0;
        expect_ev(t + HOLD_CYCLES + 2 * REPEAT_CYCLES, 0, K_RELEASE);
        wait_until(t + HOLD_CYCLES + 2 * REPEAT_CYCLES - 1);
        vectors++;
        if (level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_level_held: got %b expected 1", level[0]);
        end
        wait_until(t + HOLD_CYCLES + 2 * REPEAT_CYCLES + 6);
        repeat_en = 2'b00;
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        int c, t, r, n, e, o;
        c = cyc;
        t = c + LAT;
        obs_q.delete();
        exp_q.delete();
        repeat_en[0] = 1'b1;
        btn_raw[0]   = 1'b1;
        expect_ev(t, 0, K_PRESS);
        expect_ev(t + HOLD_CYCLES, 0, K_REPEAT);
        wait_until(t + HOLD_CYCLES + 4);
        rst = 1'b1;
        wait_until(t + HOLD_CYCLES + 5);
        vectors++;
        if (level !== 2'b00) begin
            miscompares++;
            $display("FAIL midrst_level: got %b expected 00", level);
        end
        vectors++;
        if ({pulse_press, pulse_release, pulse_repeat} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrst_pulses: got %b expected 000000", {pulse_press, pulse_release, pulse_repeat});
        end
        wait_until(t + HOLD_CYCLES + 6);
        r   = cyc;
        rst = 1'b0;
        expect_ev(r + LAT, 0, K_PRESS);
        wait_until(r + LAT - 1);
        vectors++;
        if (level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_level_before: got %b expected 0", level[0]);
        end
        wait_until(r + LAT);
        vectors++;
        if (level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_level_rise: got %b expected 1", level[0]);
        end
        wait_until(r + 8);
        btn_raw[0] = 1'b0;
        expect_ev(r + 8 + LAT, 0, K_RELEASE);
        wait_until(r + 18);
        repeat_en = 2'b00;
        exp_q.sort();
        obs_q.sort();
        n = (exp_q.size() > obs_q.size()) ? exp_q.size() : obs_q.size();
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL midrst_events[%0d]: got key %0d (cyc %0d ch %0d kind %0d) expected key %0d (cyc %0d ch %0d kind %0d)",
                         i, o, o / 8, (o / 4) % 2, o % 4, e, e / 8, (e / 4) % 2, e % 4);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_raw   = 2'b00;
        repeat_en = 2'b00;
        test_reset();
        test_press_release();
        test_glitch();
        test_auto_repeat();
        test_late_repeat_enable();
        test_release_on_wrap();
        test_reset_mid_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
